// File: rtl/branch_rs_alu_pkg.sv
// branch_rs_alu_pkg
// Shared constants for the branch reservation station and its comparator:
// the RS index / address / tag / data widths, the entry count and the
// conditional-branch funct3 encodings.
// Ports: none (package only).
package branch_rs_alu_pkg;

  localparam int BRANCH_ALU_RS_WIDTH = 2;
  localparam int ADDR_WIDTH          = 32;
  localparam int TAG_WIDTH           = 4;
  localparam int DATA_WIDTH          = 32;
  localparam int BRANCH_RS_ENTRIES   = 4;

  // Only the six real conditional branches are named; the two unused
  // encodings (010, 011) fall through to "not taken" in the comparator.
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_e;

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp
// Purely combinational branch condition evaluator. Kept separate so a
// later branch-prediction checker can reuse the same decision logic.
// Ports:
//   funct3  in   3       branch type
//   op1     in   DATA_W  first source operand (rs1)
//   op2     in   DATA_W  second source operand (rs2)
//   taken   out  1       1 = branch condition holds
module branch_cmp
  import branch_rs_alu_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (op1 == op2);
      F3_BNE:  taken = (op1 != op2);
      F3_BLT:  taken = ($signed(op1) <  $signed(op2));
      F3_BGE:  taken = ($signed(op1) >= $signed(op2));
      F3_BLTU: taken = (op1 <  op2);
      F3_BGEU: taken = (op1 >= op2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_rs_alu.sv
// branch_rs_alu
// Branch reservation station plus comparator. Dispatched conditional
// branches wait here until both operands are known (directly or captured
// from the CDB), then one at a time is evaluated and handed to the
// branch-CDB stage. An entry stays allocated until that stage returns
// finish with its RS number.
// Ports:
//   clk, rst                       clock, async active-high reset
//   disp_valid/funct3/op*/offset   dispatch interface
//   rs_full                        out: every entry busy
//   cdb_valid/cdb_tag/cdb_data     result broadcast bus
//   branchALUSignal                out: one-cycle result-valid pulse
//   branchALURSNumOut              out: index of the issued entry
//   branchALUResultOut             out: 1 = taken
//   branchALUOffsetOut             out: offset of the issued entry
//   branchALUFinish/RSNumIn        in : completion, frees an entry
module branch_rs_alu
  import branch_rs_alu_pkg::*;
#(
  parameter int RS_ENTRIES = BRANCH_RS_ENTRIES,
  parameter int RS_W       = BRANCH_ALU_RS_WIDTH,
  parameter int TAG_W      = TAG_WIDTH,
  parameter int DATA_W     = DATA_WIDTH,
  parameter int ADDR_W     = ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [2:0]        disp_funct3,
  input  logic              disp_op1_rdy,
  input  logic [DATA_W-1:0] disp_op1_val,
  input  logic [TAG_W-1:0]  disp_op1_tag,
  input  logic              disp_op2_rdy,
  input  logic [DATA_W-1:0] disp_op2_val,
  input  logic [TAG_W-1:0]  disp_op2_tag,
  input  logic [ADDR_W-1:0] disp_offset,
  output logic              rs_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              branchALUSignal,
  output logic [RS_W-1:0]   branchALURSNumOut,
  output logic              branchALUResultOut,
  output logic [ADDR_W-1:0] branchALUOffsetOut,
  input  logic              branchALUFinish,
  input  logic [RS_W-1:0]   branchALURSNumIn
);

  logic [RS_ENTRIES-1:0] busy;
  logic [RS_ENTRIES-1:0] issued;
  logic [RS_ENTRIES-1:0] op1_rdy;
  logic [RS_ENTRIES-1:0] op2_rdy;
  logic [2:0]            funct3_q [RS_ENTRIES];
  logic [DATA_W-1:0]     op1_val  [RS_ENTRIES];
  logic [DATA_W-1:0]     op2_val  [RS_ENTRIES];
  logic [TAG_W-1:0]      op1_tag  [RS_ENTRIES];
  logic [TAG_W-1:0]      op2_tag  [RS_ENTRIES];
  logic [ADDR_W-1:0]     offset_q [RS_ENTRIES];
  logic                  inflight;

  logic              free_found;
  logic [RS_W-1:0]   free_idx;
  logic              sel_valid;
  logic [RS_W-1:0]   sel_idx;
  logic              disp_fire;
  logic              disp_op1_hit;
  logic              disp_op2_hit;
  logic              sel_taken;

  // Full is judged on registered state only, so a slot freed by a finish
  // this cycle cannot be reused until the following cycle.
  assign rs_full   = &busy;
  assign disp_fire = disp_valid & ~rs_full;

  // A producer broadcasting in the same cycle as dispatch would otherwise
  // be missed, since the entry is not yet busy when the CDB is snooped.
  assign disp_op1_hit = ~disp_op1_rdy & cdb_valid & (cdb_tag == disp_op1_tag);
  assign disp_op2_hit = ~disp_op2_rdy & cdb_valid & (cdb_tag == disp_op2_tag);

  // Lowest-index free entry; scanning downward lets the lowest win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = RS_W'(i);
      end
    end
  end

  // Lowest-index ready, not-yet-issued entry. Nothing is selected while a
  // branch is in flight, so only one result is ever outstanding downstream.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!inflight && busy[i] && op1_rdy[i] && op2_rdy[i] && !issued[i]) begin
        sel_valid = 1'b1;
        sel_idx   = RS_W'(i);
      end
    end
  end

  branch_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .funct3 (funct3_q[sel_idx]),
    .op1    (op1_val[sel_idx]),
    .op2    (op2_val[sel_idx]),
    .taken  (sel_taken)
  );

  // Entry state, issue and completion. Order inside the else branch
  // matters only for the in-flight flag: an issue in the same cycle as a
  // stray finish leaves a branch in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy               <= '0;
      issued             <= '0;
      op1_rdy            <= '0;
      op2_rdy            <= '0;
      inflight           <= 1'b0;
      branchALUSignal    <= 1'b0;
      branchALURSNumOut  <= '0;
      branchALUResultOut <= 1'b0;
      branchALUOffsetOut <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        funct3_q[i] <= '0;
        op1_val[i]  <= '0;
        op2_val[i]  <= '0;
        op1_tag[i]  <= '0;
        op2_tag[i]  <= '0;
        offset_q[i] <= '0;
      end
    end else begin
      branchALUSignal <= 1'b0;

      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (busy[i] && cdb_valid) begin
          if (!op1_rdy[i] && (op1_tag[i] == cdb_tag)) begin
            op1_val[i] <= cdb_data;
            op1_rdy[i] <= 1'b1;
          end
          if (!op2_rdy[i] && (op2_tag[i] == cdb_tag)) begin
            op2_val[i] <= cdb_data;
            op2_rdy[i] <= 1'b1;
          end
        end
      end

      if (branchALUFinish) begin
        inflight <= 1'b0;
        if (busy[branchALURSNumIn]) begin
          busy[branchALURSNumIn]   <= 1'b0;
          issued[branchALURSNumIn] <= 1'b0;
        end
      end

      if (sel_valid) begin
        branchALUSignal     <= 1'b1;
        branchALURSNumOut   <= sel_idx;
        branchALUResultOut  <= sel_taken;
        branchALUOffsetOut  <= offset_q[sel_idx];
        issued[sel_idx]     <= 1'b1;
        inflight            <= 1'b1;
      end

      if (disp_fire && free_found) begin
        busy[free_idx]     <= 1'b1;
        issued[free_idx]   <= 1'b0;
        funct3_q[free_idx] <= disp_funct3;
        op1_tag[free_idx]  <= disp_op1_tag;
        op2_tag[free_idx]  <= disp_op2_tag;
        offset_q[free_idx] <= disp_offset;
        op1_rdy[free_idx]  <= disp_op1_rdy | disp_op1_hit;
        op2_rdy[free_idx]  <= disp_op2_rdy | disp_op2_hit;
        op1_val[free_idx]  <= disp_op1_hit ? cdb_data : disp_op1_val;
        op2_val[free_idx]  <= disp_op2_hit ? cdb_data : disp_op2_val;
      end
    end
  end

endmodule

// File: tb/tb_branch_rs_alu.sv
// tb_branch_rs_alu
// Directed bench for branch_rs_alu: a linear sequence of dispatch / CDB /
// finish steps with hand-computed expected outputs checked just after
// each rising edge.
// Ports: none (top-level bench).
module tb_branch_rs_alu;

  logic        clk;
  logic        rst;
  logic        disp_valid;
  logic [2:0]  disp_funct3;
  logic        disp_op1_rdy;
  logic [31:0] disp_op1_val;
  logic [3:0]  disp_op1_tag;
  logic        disp_op2_rdy;
  logic [31:0] disp_op2_val;
  logic [3:0]  disp_op2_tag;
  logic [31:0] disp_offset;
  logic        rs_full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        branchALUSignal;
  logic [1:0]  branchALURSNumOut;
  logic        branchALUResultOut;
  logic [31:0] branchALUOffsetOut;
  logic        branchALUFinish;
  logic [1:0]  branchALURSNumIn;

  int vectors;
  int miscompares;

  branch_rs_alu dut (
    .clk                (clk),
    .rst                (rst),
    .disp_valid         (disp_valid),
    .disp_funct3        (disp_funct3),
    .disp_op1_rdy       (disp_op1_rdy),
    .disp_op1_val       (disp_op1_val),
    .disp_op1_tag       (disp_op1_tag),
    .disp_op2_rdy       (disp_op2_rdy),
    .disp_op2_val       (disp_op2_val),
    .disp_op2_tag       (disp_op2_tag),
    .disp_offset        (disp_offset),
    .rs_full            (rs_full),
    .cdb_valid          (cdb_valid),
    .cdb_tag            (cdb_tag),
    .cdb_data           (cdb_data),
    .branchALUSignal    (branchALUSignal),
    .branchALURSNumOut  (branchALURSNumOut),
    .branchALUResultOut (branchALUResultOut),
    .branchALUOffsetOut (branchALUOffsetOut),
    .branchALUFinish    (branchALUFinish),
    .branchALURSNumIn   (branchALURSNumIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f3,
                               input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                               input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                               input logic [31:0] off);
    disp_valid   = 1'b1;
    disp_funct3  = f3;
    disp_op1_rdy = r1;
    disp_op1_val = v1;
    disp_op1_tag = t1;
    disp_op2_rdy = r2;
    disp_op2_val = v2;
    disp_op2_tag = t2;
    disp_offset  = off;
    tick();
    disp_valid   = 1'b0;
  endtask

  task automatic applyFinish(input logic [1:0] idx);
    branchALUFinish  = 1'b1;
    branchALURSNumIn = idx;
    tick();
    branchALUFinish  = 1'b0;
  endtask

  // One fully ready branch into an empty station: it must land in entry 0
  // and pulse exactly one cycle, two edges after dispatch.
  task automatic runSingle(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] off, input logic exp_taken);
    applyStimulus(f3, 1'b1, a, 4'd0, 1'b1, b, 4'd0, off);
    checkOutput({tag, "_early"}, 32'(branchALUSignal), 32'd0);
    tick();
    checkOutput({tag, "_sig"}, 32'(branchALUSignal), 32'd1);
    checkOutput({tag, "_res"}, 32'(branchALUResultOut), 32'(exp_taken));
    checkOutput({tag, "_off"}, branchALUOffsetOut, off);
    checkOutput({tag, "_rs"}, 32'(branchALURSNumOut), 32'd0);
    tick();
    checkOutput({tag, "_pulse_end"}, 32'(branchALUSignal), 32'd0);
    applyFinish(2'd0);
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    disp_valid       = 1'b0;
    disp_funct3      = 3'b000;
    disp_op1_rdy     = 1'b0;
    disp_op1_val     = '0;
    disp_op1_tag     = '0;
    disp_op2_rdy     = 1'b0;
    disp_op2_val     = '0;
    disp_op2_tag     = '0;
    disp_offset      = '0;
    cdb_valid        = 1'b0;
    cdb_tag          = '0;
    cdb_data         = '0;
    branchALUFinish  = 1'b0;
    branchALURSNumIn = '0;

    #12;
    checkOutput("reset_sig", 32'(branchALUSignal), 32'd0);
    checkOutput("reset_rs", 32'(branchALURSNumOut), 32'd0);
    checkOutput("reset_res", 32'(branchALUResultOut), 32'd0);
    checkOutput("reset_off", branchALUOffsetOut, 32'd0);
    checkOutput("reset_full", 32'(rs_full), 32'd0);
    rst = 1'b0;
    tick();

    // Compare rules, each through a fresh entry 0.
    runSingle("beq", 3'b000, 32'd5, 32'd5, 32'hFFFF_FFF8, 1'b1);
    runSingle("blt", 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h0000_0010, 1'b1);
    runSingle("bltu", 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h0000_0020, 1'b0);
    runSingle("f3_010", 3'b010, 32'd5, 32'd5, 32'h0000_0030, 1'b0);
    runSingle("bge", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h0000_0034, 1'b0);
    runSingle("bgeu", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h0000_0038, 1'b1);
    runSingle("bne", 3'b001, 32'd4, 32'd9, 32'h0000_003C, 1'b1);

    // op2 waits on tag 3; a broadcast on another tag must not wake it.
    applyStimulus(3'b000, 1'b1, 32'd7, 4'd0, 1'b0, 32'd0, 4'd3, 32'h0000_0050);
    tick();
    checkOutput("pend_wait", 32'(branchALUSignal), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'd7;
    tick();
    cdb_valid = 1'b0;
    tick();
    checkOutput("pend_wrong_tag", 32'(branchALUSignal), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'd7;
    tick();
    cdb_valid = 1'b0;
    checkOutput("pend_capture_edge", 32'(branchALUSignal), 32'd0);
    tick();
    checkOutput("pend_sig", 32'(branchALUSignal), 32'd1);
    checkOutput("pend_res", 32'(branchALUResultOut), 32'd1);
    checkOutput("pend_off", branchALUOffsetOut, 32'h0000_0050);
    applyFinish(2'd0);

    // Same-cycle dispatch and CDB on tag 3: BNE 7 vs captured 7 -> not taken.
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'd7;
    applyStimulus(3'b001, 1'b1, 32'd7, 4'd0, 1'b0, 32'd0, 4'd3, 32'h0000_0060);
    cdb_valid = 1'b0;
    tick();
    checkOutput("bypass_sig", 32'(branchALUSignal), 32'd1);
    checkOutput("bypass_res", 32'(branchALUResultOut), 32'd0);
    checkOutput("bypass_off", branchALUOffsetOut, 32'h0000_0060);
    applyFinish(2'd0);

    // Fill all four entries with branches waiting on tag 9.
    applyStimulus(3'b000, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd9, 32'h0000_0070);
    applyStimulus(3'b000, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd9, 32'h0000_0074);
    applyStimulus(3'b000, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd9, 32'h0000_0078);
    checkOutput("full_3", 32'(rs_full), 32'd0);
    applyStimulus(3'b000, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd9, 32'h0000_007C);
    checkOutput("full_4", 32'(rs_full), 32'd1);
    applyStimulus(3'b000, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0, 32'h0000_0080);
    checkOutput("full_5th_state", 32'(rs_full), 32'd1);
    tick();
    checkOutput("full_5th_no_issue", 32'(branchALUSignal), 32'd0);
    // Finish frees entry 2 while a dispatch arrives: the dispatch is dropped.
    disp_valid = 1'b1; disp_funct3 = 3'b000;
    disp_op1_rdy = 1'b1; disp_op1_val = 32'd2;
    disp_op2_rdy = 1'b1; disp_op2_val = 32'd2;
    disp_offset = 32'h0000_0044;
    applyFinish(2'd2);
    disp_valid = 1'b0;
    checkOutput("full_freed", 32'(rs_full), 32'd0);
    tick();
    checkOutput("full_drop_a", 32'(branchALUSignal), 32'd0);
    tick();
    checkOutput("full_drop_b", 32'(branchALUSignal), 32'd0);
    applyStimulus(3'b000, 1'b1, 32'd3, 4'd0, 1'b1, 32'd3, 4'd0, 32'h0000_0040);
    checkOutput("refill_full", 32'(rs_full), 32'd1);
    tick();
    checkOutput("refill_sig", 32'(branchALUSignal), 32'd1);
    checkOutput("refill_rs", 32'(branchALURSNumOut), 32'd2);
    checkOutput("refill_off", branchALUOffsetOut, 32'h0000_0040);
    applyFinish(2'd2);
    applyFinish(2'd0);
    applyFinish(2'd1);
    applyFinish(2'd3);
    checkOutput("drain_full", 32'(rs_full), 32'd0);

    // Entry 0 blocked on tag 9; entries 1 and 2 ready. Entry 1 issues as
    // entry 2 is being written, and entry 2 waits for finish(1).
    applyStimulus(3'b000, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd9, 32'h0000_0090);
    applyStimulus(3'b000, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 32'h0000_0100);
    applyStimulus(3'b001, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 32'h0000_0200);
    checkOutput("prio_sig1", 32'(branchALUSignal), 32'd1);
    checkOutput("prio_rs1", 32'(branchALURSNumOut), 32'd1);
    checkOutput("prio_off1", branchALUOffsetOut, 32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("prio_hold", 32'(branchALUSignal), 32'd0);
    end
    applyFinish(2'd1);
    checkOutput("prio_finish_edge", 32'(branchALUSignal), 32'd0);
    tick();
    checkOutput("prio_sig2", 32'(branchALUSignal), 32'd1);
    checkOutput("prio_rs2", 32'(branchALURSNumOut), 32'd2);
    checkOutput("prio_res2", 32'(branchALUResultOut), 32'd1);
    checkOutput("prio_off2", branchALUOffsetOut, 32'h0000_0200);
    applyFinish(2'd2);

    // Reset while a pulse is on the outputs; a late finish is ignored.
    applyStimulus(3'b000, 1'b1, 32'd8, 4'd0, 1'b1, 32'd8, 4'd0, 32'h0000_0300);
    tick();
    checkOutput("rst_pre_sig", 32'(branchALUSignal), 32'd1);
    checkOutput("rst_pre_rs", 32'(branchALURSNumOut), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_sig", 32'(branchALUSignal), 32'd0);
    checkOutput("rst_mid_rs", 32'(branchALURSNumOut), 32'd0);
    checkOutput("rst_mid_res", 32'(branchALUResultOut), 32'd0);
    checkOutput("rst_mid_off", branchALUOffsetOut, 32'd0);
    checkOutput("rst_mid_full", 32'(rs_full), 32'd0);
    rst = 1'b0;
    applyFinish(2'd1);
    tick();
    checkOutput("rst_late_finish", 32'(branchALUSignal), 32'd0);
    applyStimulus(3'b000, 1'b1, 32'd6, 4'd0, 1'b1, 32'd6, 4'd0, 32'h0000_0400);
    tick();
    checkOutput("rst_after_sig", 32'(branchALUSignal), 32'd1);
    checkOutput("rst_after_rs", 32'(branchALURSNumOut), 32'd0);
    checkOutput("rst_after_off", branchALUOffsetOut, 32'h0000_0400);
    applyFinish(2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_rs_alu.md
Name: branch_rs_alu

Overview:
- Branch reservation station plus comparator for the out-of-order core.
- Accepts dispatched conditional branches and captures missing operands from the CDB.
- Issues one ready branch at a time and presents taken/not-taken plus offset to the downstream branch-CDB stage.
- Frees the entry when that stage returns finish with the matching RS number.

Parameters:
- RS_ENTRIES, 4, number of reservation-station entries.
- RS_W, 2, RS index width; must equal `branchALURSWidth.
- TAG_W, 4, ROB/rename tag width carried on the CDB.
- DATA_W, 32, operand width.
- ADDR_W, 32, offset width; must equal `addrWidth.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- disp_valid  in  1  dispatch a branch this cycle.
- disp_funct3  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- disp_op1_rdy  in  1  op1 value is valid.
- disp_op1_val  in  DATA_W  op1 value.
- disp_op1_tag  in  TAG_W  op1 producer tag when not ready.
- disp_op2_rdy / disp_op2_val / disp_op2_tag  in  1/DATA_W/TAG_W  same for op2.
- disp_offset  in  ADDR_W  sign-extended branch immediate.
- rs_full  out  1  no free entry.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB tag.
- cdb_data  in  DATA_W  CDB value.
- branchALUSignal  out  1  one-cycle result-valid pulse.
- branchALURSNumOut  out  RS_W  index of the issued entry.
- branchALUResultOut  out  1  1 = taken.
- branchALUOffsetOut  out  ADDR_W  offset of the issued entry.
- branchALUFinish  in  1  downstream completion pulse.
- branchALURSNumIn  in  RS_W  entry to free.

Behaviour:
- Reset (async, rst=1) values:
  - all entries busy=0, issued=0.
  - inflight=0.
  - branchALUSignal=0, branchALURSNumOut=0, branchALUResultOut=0, branchALUOffsetOut=0.
  - rs_full=0.
- Reset mid-operation drops every entry, including an issued one. A finish arriving after reset is ignored because the entry is not busy.
- rs_full is combinational from registered state: all entries busy. A slot freed this cycle is not usable until next cycle.
- Dispatch:
  - On disp_valid & ~rs_full, write the lowest-index free entry: busy=1, issued=0, funct3, operands, tags, offset.
  - disp_valid while full is ignored with no state change.
  - Same-cycle bypass: if an operand is not ready and cdb_valid & cdb_tag == its tag, store cdb_data and mark it ready.
- CDB capture: each cycle, every busy entry with a not-ready operand whose tag matches cdb_tag while cdb_valid stores cdb_data and sets that operand ready.
- Issue:
  - When inflight=0, select the lowest-index entry with busy & op1_rdy & op2_rdy & ~issued.
  - At the next edge: branchALUSignal=1 for exactly one cycle, RSNumOut=index, OffsetOut=offset, ResultOut=compare. Set issued=1 and inflight=1.
  - Latency: operands ready in registered state at edge t → signal high after edge t+1.
  - An operand captured from the CDB at edge t is first eligible for selection in the cycle after edge t.
- Compare rules:
  - BEQ: a==b. BNE: a!=b.
  - BLT / BGE: signed. BLTU / BGEU: unsigned.
  - Funct3 010/011 → not taken.
- Completion:
  - On branchALUFinish, clear busy/issued of entry branchALURSNumIn and clear inflight.
  - Finish for a non-busy entry clears only inflight.
  - Finish and a new dispatch in the same cycle are both honoured. Dispatch uses a slot free before the edge.
- Outputs other than branchALUSignal hold their last values between pulses; downstream samples them only with the signal.

Decomposition:
- Shared defines (existing defines.v):
  - `branchALURSWidth, `addrWidth, tag/data widths.
  - BEQ..BGEU funct3 constants.
  - Entry-count constant.
- Natural sub-module: branch_cmp, a combinational funct3/op1/op2 → taken unit, reusable by a later branch-prediction checker.
- Priority-select and free-slot find stay inline.

Test Plan:
- Reset: assert rst mid-issue → all outputs 0 and rs_full=0 immediately; a later finish has no effect.
- Ready BEQ dispatch, op1=op2=5, offset=-8:
  - signal pulses 2 cycles after dispatch with Result=1, Offset=0xFFFFFFF8, RSNum=0.
  - finish(0) frees entry 0.
- BLT 0xFFFFFFFF vs 1 → taken. BLTU with the same operands → not taken. Funct3 010 → not taken.
- op2 pending on tag 3:
  - no issue until cdb_valid, tag 3, data 7.
  - same-cycle dispatch+CDB bypass on tag 3 also captures 7.
- Dispatch 4 entries → rs_full=1 and a 5th dispatch is ignored. Finish frees one entry; rs_full drops the next cycle.
- Entries 1 and 2 both ready: entry 1 issues first; entry 2 issues only after finish(1), never while inflight.
